// File: rtl/ram_dp_clear.sv
// ram_dp_clear: simple-dual-port flop RAM with lane write mask,
// registered read, selectable read-during-write and a clear sweep.
module ram_dp_clear #(
    parameter int Width       = 8,
    parameter int LaneWidth   = 8,
    parameter int AddressSize = 4,
    parameter int ReadMode    = 0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       we,
    input  logic [AddressSize-1:0]     waddr,
    input  logic [Width/LaneWidth-1:0] wmask,
    input  logic [Width-1:0]           D,
    input  logic                       re,
    input  logic [AddressSize-1:0]     raddr,
    output logic [Width-1:0]           Q,
    output logic                       valid,
    input  logic                       clr,
    output logic                       busy,
    output logic                       wdrop
);

    localparam int Lanes = Width / LaneWidth;
    localparam int Depth = 2 ** AddressSize;
    localparam logic [AddressSize-1:0] Last = AddressSize'(Depth - 1);

    typedef enum logic {
        IDLE,
        CLEAR
    } state_t;

    state_t                 state;
    state_t                 state_nx;
    logic [AddressSize-1:0] cnt;
    logic [Width-1:0]       mem [Depth];
    logic [Width-1:0]       merged;
    logic                   wr_ok;
    logic                   drop;
    logic                   sweep;
    logic                   fwd;

    // state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nx;
    end

    // next state plus write accept / drop / sweep qualifiers
    always_comb begin
        state_nx = state;
        wr_ok    = 1'b0;
        drop     = 1'b0;
        sweep    = 1'b0;
        unique case (state)
            IDLE: begin
                wr_ok = we && !clr;
                drop  = we && clr;
                if (clr) state_nx = CLEAR;
            end
            CLEAR: begin
                sweep = 1'b1;
                drop  = we;
                if (cnt == Last) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // lane merge of incoming data over the currently stored word
    always_comb begin
        merged = mem[waddr];
        for (int i = 0; i < Lanes; i++) begin
            if (wmask[i]) merged[i*LaneWidth +: LaneWidth] = D[i*LaneWidth +: LaneWidth];
        end
    end

    assign fwd  = (ReadMode == 1) && wr_ok && (raddr == waddr);
    assign busy = (state == CLEAR);

    // sweep pointer, restarted on entry and bumped every clear cycle
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                       cnt <= '0;
        else if (state == IDLE && clr)  cnt <= '0;
        else if (sweep)                 cnt <= cnt + AddressSize'(1);
    end

    // storage array: sweep zeroing takes priority over writes
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < Depth; i++) mem[i] <= '0;
        end else if (sweep) begin
            mem[cnt] <= '0;
        end else if (wr_ok) begin
            mem[waddr] <= merged;
        end
    end

    // registered read port and drop indicator
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            Q     <= '0;
            valid <= 1'b0;
            wdrop <= 1'b0;
        end else begin
            valid <= re;
            wdrop <= drop;
            if (re) Q <= fwd ? merged : mem[raddr];
        end
    end

endmodule

// File: tb/tb_ram_dp_clear.sv
// tb_ram_dp_clear: random and directed checks of ram_dp_clear
// against a word-array model, read-first and write-first instances.
module tb_ram_dp_clear;

    logic        clk;
    logic        rst;
    logic        we;
    logic [3:0]  waddr;
    logic [1:0]  wmask;
    logic [15:0] D;
    logic        re;
    logic [3:0]  raddr;
    logic        clr;
    logic [15:0] q0, q1;
    logic        v0, v1, b0, b1, wd0, wd1;

    int n_cmp;
    int n_bad;

    logic [15:0] m [16];
    int          sw_left;
    int          sw_ptr;
    logic [15:0] eq0, eq1;
    logic        ev, ewd;

    ram_dp_clear #(.Width(16), .LaneWidth(8), .AddressSize(4), .ReadMode(0)) u0 (
        .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wmask(wmask), .D(D),
        .re(re), .raddr(raddr), .Q(q0), .valid(v0), .clr(clr), .busy(b0),
        .wdrop(wd0)
    );

    ram_dp_clear #(.Width(16), .LaneWidth(8), .AddressSize(4), .ReadMode(1)) u1 (
        .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wmask(wmask), .D(D),
        .re(re), .raddr(raddr), .Q(q1), .valid(v1), .clr(clr), .busy(b1),
        .wdrop(wd1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic mreset();
        for (int i = 0; i < 16; i++) m[i] = 16'h0;
        sw_left = 0;
        sw_ptr  = 0;
        eq0     = 16'h0;
        eq1     = 16'h0;
        ev      = 1'b0;
        ewd     = 1'b0;
    endtask

    task automatic cyc(input logic w, input logic [3:0] wa, input logic [1:0] wm,
                       input logic [15:0] d, input logic r, input logic [3:0] ra,
                       input logic c);
        logic        sweeping;
        logic        acc;
        logic [15:0] old;
        logic [15:0] mw;
        @(negedge clk);
        we = w; waddr = wa; wmask = wm; D = d; re = r; raddr = ra; clr = c;
        @(posedge clk);
        sweeping = (sw_left > 0);
        acc      = w && !sweeping && !c;
        ewd      = w && (sweeping || c);
        old      = m[ra];
        mw       = m[wa];
        if (wm[0]) mw[7:0]  = d[7:0];
        if (wm[1]) mw[15:8] = d[15:8];
        if (r) begin
            eq0 = old;
            eq1 = (acc && ra == wa) ? mw : old;
            ev  = 1'b1;
        end else begin
            ev  = 1'b0;
        end
        if (acc) m[wa] = mw;
        if (sweeping) begin
            m[sw_ptr] = 16'h0;
            sw_ptr    = (sw_ptr + 1) % 16;
            sw_left--;
        end else if (c) begin
            sw_ptr  = 0;
            sw_left = 16;
        end
        #1;
        chk("q_rf",   32'(q0),  32'(eq0));
        chk("q_wf",   32'(q1),  32'(eq1));
        chk("valid0", 32'(v0),  32'(ev));
        chk("valid1", 32'(v1),  32'(ev));
        chk("busy0",  32'(b0),  32'(sw_left > 0));
        chk("busy1",  32'(b1),  32'(sw_left > 0));
        chk("wdrop0", 32'(wd0), 32'(ewd));
        chk("wdrop1", 32'(wd1), 32'(ewd));
    endtask

    task automatic idle_inputs();
        we = 1'b0; waddr = 4'h0; wmask = 2'b00; D = 16'h0;
        re = 1'b0; raddr = 4'h0; clr = 1'b0;
    endtask

    task automatic read_all_zero(input string tag);
        for (int a = 0; a < 16; a++) begin
            cyc(1'b0, 4'h0, 2'b00, 16'h0, 1'b1, 4'(a), 1'b0);
            chk(tag, 32'(q0), 32'h0);
        end
    endtask

    initial begin
        int nb;
        int nd;
        n_cmp = 0;
        n_bad = 0;
        rst   = 1'b0;
        idle_inputs();
        mreset();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_q0",    32'(q0),  32'h0);
        chk("rst_q1",    32'(q1),  32'h0);
        chk("rst_valid", 32'(v0),  32'h0);
        chk("rst_busy",  32'(b0),  32'h0);
        chk("rst_wdrop", 32'(wd0), 32'h0);
        @(negedge clk);
        rst = 1'b1;

        read_all_zero("readback0");

        cyc(1'b1, 4'd3, 2'b11, 16'hBEEF, 1'b0, 4'd0, 1'b0);
        cyc(1'b1, 4'd3, 2'b10, 16'h1234, 1'b0, 4'd0, 1'b0);
        cyc(1'b0, 4'd0, 2'b00, 16'h0, 1'b1, 4'd3, 1'b0);
        chk("mask_q", 32'(q0), 32'h12EF);
        cyc(1'b1, 4'd3, 2'b00, 16'hFFFF, 1'b0, 4'd0, 1'b0);
        cyc(1'b0, 4'd0, 2'b00, 16'h0, 1'b1, 4'd3, 1'b0);
        chk("mask0_q", 32'(q0), 32'h12EF);

        cyc(1'b1, 4'd5, 2'b11, 16'h0011, 1'b0, 4'd0, 1'b0);
        cyc(1'b1, 4'd5, 2'b11, 16'h0022, 1'b1, 4'd5, 1'b0);
        chk("rdw_rf", 32'(q0), 32'h0011);
        chk("rdw_wf", 32'(q1), 32'h0022);
        cyc(1'b0, 4'd0, 2'b00, 16'h0, 1'b1, 4'd5, 1'b0);
        chk("rdw_after_rf", 32'(q0), 32'h0022);
        chk("rdw_after_wf", 32'(q1), 32'h0022);

        for (int a = 0; a < 16; a++)
            cyc(1'b1, 4'(a), 2'b11, 16'hA5A5, 1'b0, 4'd0, 1'b0);
        cyc(1'b1, 4'd0, 2'b11, 16'hFFFF, 1'b0, 4'd0, 1'b1);
        nb = int'(b0);
        nd = int'(wd0);
        for (int k = 0; k < 20; k++) begin
            cyc(1'(k == 5 || k == 9), 4'd7, 2'b11, 16'hFFFF,
                1'(k == 3), 4'd15, 1'(k == 8));
            if (k == 3) chk("sweep_rd15", 32'(q0), 32'hA5A5);
            nb += int'(b0);
            nd += int'(wd0);
        end
        chk("busy_len",  32'(nb), 32'd16);
        chk("wdrop_cnt", 32'(nd), 32'd3);
        read_all_zero("clr_zero");

        cyc(1'b1, 4'd12, 2'b11, 16'h5A5A, 1'b0, 4'd0, 1'b0);
        cyc(1'b0, 4'd0, 2'b00, 16'h0, 1'b0, 4'd0, 1'b1);
        for (int k = 0; k < 7; k++)
            cyc(1'b0, 4'd0, 2'b00, 16'h0, 1'b1, 4'd12, 1'b0);
        chk("pre_ar_q", 32'(q0), 32'h5A5A);
        #2;
        rst = 1'b0;
        idle_inputs();
        #1;
        mreset();
        chk("ar_busy",  32'(b0), 32'h0);
        chk("ar_valid", 32'(v0), 32'h0);
        chk("ar_q0",    32'(q0), 32'h0);
        chk("ar_q1",    32'(q1), 32'h0);
        @(negedge clk);
        rst = 1'b1;
        read_all_zero("ar_zero");
        cyc(1'b1, 4'd9, 2'b11, 16'h003C, 1'b0, 4'd0, 1'b0);
        cyc(1'b0, 4'd0, 2'b00, 16'h0, 1'b1, 4'd9, 1'b0);
        chk("ar_wr", 32'(q0), 32'h003C);

        for (int n = 0; n < 600; n++) begin
            logic        w, r, c;
            logic [3:0]  wa, ra;
            logic [1:0]  wm;
            logic [15:0] d;
            w  = 1'($urandom_range(0, 1));
            r  = 1'($urandom_range(0, 9) < 6);
            c  = 1'($urandom_range(0, 39) == 0);
            wa = 4'($urandom);
            ra = ($urandom_range(0, 3) == 0) ? wa : 4'($urandom);
            wm = 2'($urandom);
            d  = 16'($urandom);
            cyc(w, wa, wm, d, r, ra, c);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
